// File: rtl/assoc_cache_4way_pkg.sv
// assoc_cache_4way_pkg: geometry constants, controller state and address field helpers
package assoc_cache_4way_pkg;
  localparam int TAG_W = 24;
  localparam int IDX_W = 4;
  localparam int WORD_W = 2;
  localparam int NUM_SETS = 16;
  localparam int NUM_WAYS = 4;
  localparam int WAY_W = 2;
  typedef enum logic {IDLE, FILL} state_t;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return TAG_W'(a >> 8);
  endfunction
  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'(a >> 4);
  endfunction
  function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] a);
    return WORD_W'(a >> 2);
  endfunction
endpackage

// File: rtl/assoc_cache_4way_way_compare.sv
// cache_way_compare: one way's valid/tag match, reporting its own index when it hits
module cache_way_compare
  import assoc_cache_4way_pkg::*;
#(
  parameter int WAY = 0
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] stored_tag,
  input  logic [TAG_W-1:0] tag,
  output logic             hit,
  output logic [WAY_W-1:0] way
);
  always_comb begin
    hit = valid && (stored_tag == tag);
    way = hit ? WAY_W'(WAY) : '0;
  end
endmodule

// File: rtl/assoc_cache_4way.sv
// assoc_cache_4way: 4-way set-associative word cache with an internal deterministic line-fill source
module assoc_cache_4way
  import assoc_cache_4way_pkg::*;
#(
  parameter int LINE_SIZE = 32,
  parameter int MISS_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LINE_SIZE-1:0] address,
  input  logic                 c_read_i,
  input  logic                 c_wr_i,
  output logic                 busywait,
  output logic [LINE_SIZE-1:0] data
);
  state_t state;
  logic [7:0] cnt;
  logic [LINE_SIZE-1:0] data_reg;
  logic [NUM_WAYS-1:0] valid [NUM_SETS];
  logic [NUM_WAYS-1:0] usable [NUM_SETS];
  logic [TAG_W-1:0] tags [NUM_SETS][NUM_WAYS];
  logic [LINE_SIZE-1:0] words [NUM_SETS][NUM_WAYS][4];
  logic [TAG_W-1:0] lat_tag;
  logic [IDX_W-1:0] lat_idx;
  logic [WAY_W-1:0] victim;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [WORD_W-1:0] word;
  logic [NUM_WAYS-1:0] hits;
  logic [WAY_W-1:0] way_sel [NUM_WAYS];
  logic [WAY_W-1:0] hit_way, inv_w, nru_w, victim_c;
  logic has_inv, has_nru, req, access, miss;
  logic [NUM_WAYS-1:0] use_set, use_next;

  always_comb begin
    tag = addr_tag(address);
    idx = addr_idx(address);
    word = addr_word(address);
  end

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_cmp
    cache_way_compare #(.WAY(g)) u_cmp (
      .valid(valid[idx][g]),
      .stored_tag(tags[idx][g]),
      .tag(tag),
      .hit(hits[g]),
      .way(way_sel[g])
    );
  end

  always_comb begin
    hit_way = way_sel[0] | way_sel[1] | way_sel[2] | way_sel[3];
    req = c_read_i || c_wr_i;
    access = (state == IDLE) && req && (|hits);
    miss = (state == IDLE) && req && !(|hits);
    busywait = !reset && ((state == FILL) || miss);
    data = access ? words[idx][hit_way][word] : data_reg;
    use_set = usable[idx] | (NUM_WAYS'(1) << hit_way);
    use_next = (&use_set) ? (NUM_WAYS'(1) << hit_way) : use_set;
  end

  // Scan high-to-low so the lowest-index candidate wins.
  always_comb begin
    has_inv = 1'b0;
    has_nru = 1'b0;
    inv_w = '0;
    nru_w = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid[idx][i]) begin
        has_inv = 1'b1;
        inv_w = WAY_W'(i);
      end
      if (!usable[idx][i]) begin
        has_nru = 1'b1;
        nru_w = WAY_W'(i);
      end
    end
    victim_c = has_inv ? inv_w : has_nru ? nru_w : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      data_reg <= '0;
      valid <= '{default: '0};
      usable <= '{default: '0};
    end else if (state == IDLE) begin
      if (access) begin
        data_reg <= data;
        usable[idx] <= use_next;
        if (c_wr_i) words[idx][hit_way][word] <= address;
      end else if (req) begin
        lat_tag <= tag;
        lat_idx <= idx;
        victim <= victim_c;
        cnt <= '0;
        state <= FILL;
      end
    end else begin
      cnt <= cnt + 8'd1;
      if (cnt == 8'(MISS_LATENCY - 1)) begin
        valid[lat_idx][victim] <= 1'b1;
        tags[lat_idx][victim] <= lat_tag;
        for (int w = 0; w < 4; w++) words[lat_idx][victim][w] <= {lat_tag, lat_idx, WORD_W'(w), 2'b00};
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_assoc_cache_4way.sv
// tb_assoc_cache_4way: randomized and directed checks against a set/way reference model
module tb_assoc_cache_4way;
  logic clk = 0;
  logic reset = 0;
  logic [31:0] address = '0;
  logic c_read_i = 0;
  logic c_wr_i = 0;
  logic busywait;
  logic [31:0] data;
  int checks = 0;
  int errors = 0;

  bit m_valid [16][4];
  bit m_use [16][4];
  logic [23:0] m_tag [16][4];
  logic [31:0] m_word [16][4][4];

  assoc_cache_4way dut (
    .clk(clk), .reset(reset), .address(address),
    .c_read_i(c_read_i), .c_wr_i(c_wr_i), .busywait(busywait), .data(data)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0;
        m_use[s][w] = 0;
      end
  endtask

  // Expected busy cycles, returned word, and resulting state for one access held until done.
  task automatic model_access(input logic [31:0] a, input bit wr, output int eb, output logic [31:0] ed);
    int s, w, way, n;
    s = int'(a[7:4]);
    w = int'(a[3:2]);
    way = -1;
    for (int i = 0; i < 4; i++) if (m_valid[s][i] && m_tag[s][i] == a[31:8]) way = i;
    eb = 0;
    if (way < 0) begin
      eb = 5;
      for (int i = 3; i >= 0; i--) if (!m_use[s][i]) way = i;
      for (int i = 3; i >= 0; i--) if (!m_valid[s][i]) way = i;
      if (way < 0) way = 0;
      m_valid[s][way] = 1;
      m_tag[s][way] = a[31:8];
      for (int k = 0; k < 4; k++) m_word[s][way][k] = {a[31:4], 4'(k * 4)};
    end
    ed = m_word[s][way][w];
    if (wr) m_word[s][way][w] = a;
    m_use[s][way] = 1;
    n = 0;
    for (int i = 0; i < 4; i++) n += m_use[s][i];
    if (n == 4) for (int i = 0; i < 4; i++) m_use[s][i] = (i == way);
  endtask

  task automatic do_access(input logic [31:0] a, input bit rd, input bit wr, output int busy, output logic [31:0] d);
    @(negedge clk);
    address = a;
    c_read_i = rd;
    c_wr_i = wr;
    #1;
    busy = 0;
    while (busywait === 1'b1 && busy < 20) begin
      busy++;
      @(posedge clk);
      #1;
    end
    d = data;
    @(posedge clk);
    #1;
    c_read_i = 0;
    c_wr_i = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    c_read_i = 1;
    address = 32'h8000009A;
    #1;
    checks++;
    if (busywait !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busywait); end
    @(posedge clk);
    @(negedge clk);
    c_read_i = 0;
    #1;
    checks++;
    if (data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data); end
    @(negedge clk);
    reset = 0;
    model_reset();
    #1;
    checks++;
    if (busywait !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b exp 0", busywait); end
  endtask

  task automatic test_first_miss();
    int b, eb;
    logic [31:0] d, ed;
    model_access(32'h8000009A, 0, eb, ed);
    do_access(32'h8000009A, 1, 0, b, d);
    checks++;
    if (b !== 5) begin errors++; $display("FAIL first_miss_busy got %0d exp 5", b); end
    checks++;
    if (d !== 32'h80000098) begin errors++; $display("FAIL first_miss_data got %h exp 80000098", d); end
    model_access(32'h80000094, 0, eb, ed);
    do_access(32'h80000094, 1, 0, b, d);
    checks++;
    if (b !== 0) begin errors++; $display("FAIL same_line_busy got %0d exp 0", b); end
    checks++;
    if (d !== 32'h80000094) begin errors++; $display("FAIL same_line_data got %h exp 80000094", d); end
    @(negedge clk);
    checks++;
    if (data !== 32'h80000094) begin errors++; $display("FAIL data_hold got %h exp 80000094", data); end
  endtask

  task automatic test_set0();
    int b, eb;
    logic [31:0] d, ed;
    model_access(32'h00000002, 0, eb, ed);
    do_access(32'h00000002, 1, 0, b, d);
    checks++;
    if (b !== 5) begin errors++; $display("FAIL set0_busy got %0d exp 5", b); end
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL set0_data got %h exp 0", d); end
    model_access(32'h8000009C, 0, eb, ed);
    do_access(32'h8000009C, 1, 0, b, d);
    checks++;
    if (b !== 0 || d !== 32'h8000009C) begin errors++; $display("FAIL set9_kept got busy %0d data %h exp 0 8000009c", b, d); end
  endtask

  task automatic test_eviction();
    int b, eb;
    logic [31:0] a, d, ed;
    for (int t = 1; t <= 5; t++) begin
      a = {24'(t), 4'h9, 4'h4};
      model_access(a, 0, eb, ed);
      do_access(a, 1, 0, b, d);
      checks++;
      if (b !== eb || d !== ed) begin errors++; $display("FAIL evict_fill tag %0d got busy %0d data %h exp %0d %h", t, b, d, eb, ed); end
      model_access(a, 0, eb, ed);
      do_access(a, 1, 0, b, d);
      checks++;
      if (b !== 0 || d !== ed) begin errors++; $display("FAIL evict_hit tag %0d got busy %0d data %h exp 0 %h", t, b, d, ed); end
    end
    a = 32'h00000194;
    model_access(a, 0, eb, ed);
    do_access(a, 1, 0, b, d);
    checks++;
    if (b !== 5 || d !== 32'h00000194) begin errors++; $display("FAIL evicted_remiss got busy %0d data %h exp 5 00000194", b, d); end
  endtask

  task automatic test_write();
    int b, eb;
    logic [31:0] d, ed;
    model_access(32'h8000009A, 0, eb, ed);
    do_access(32'h8000009A, 1, 0, b, d);
    checks++;
    if (b !== eb || d !== ed) begin errors++; $display("FAIL write_pre got busy %0d data %h exp %0d %h", b, d, eb, ed); end
    model_access(32'h8000009A, 1, eb, ed);
    do_access(32'h8000009A, 0, 1, b, d);
    checks++;
    if (b !== 0) begin errors++; $display("FAIL write_busy got %0d exp 0", b); end
    model_access(32'h8000009A, 0, eb, ed);
    do_access(32'h8000009A, 1, 0, b, d);
    checks++;
    if (b !== 0 || d !== 32'h8000009A) begin errors++; $display("FAIL write_readback got busy %0d data %h exp 0 8000009a", b, d); end
    model_access(32'h80000096, 1, eb, ed);
    do_access(32'h80000096, 1, 1, b, d);
    checks++;
    if (b !== 0 || d !== ed) begin errors++; $display("FAIL rdwr_both got busy %0d data %h exp 0 %h", b, d, ed); end
    model_access(32'h80000094, 0, eb, ed);
    do_access(32'h80000094, 1, 0, b, d);
    checks++;
    if (d !== 32'h80000096) begin errors++; $display("FAIL rdwr_readback got %h exp 80000096", d); end
  endtask

  task automatic test_reset_mid_fill();
    int b, eb;
    logic [31:0] d, ed;
    @(negedge clk);
    address = 32'h12345678;
    c_read_i = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (busywait !== 1'b0) begin errors++; $display("FAIL midfill_reset_busy got %0b exp 0", busywait); end
    @(negedge clk);
    reset = 0;
    c_read_i = 0;
    model_reset();
    model_access(32'h12345678, 0, eb, ed);
    do_access(32'h12345678, 1, 0, b, d);
    checks++;
    if (b !== 5 || d !== 32'h12345678) begin errors++; $display("FAIL midfill_remiss got busy %0d data %h exp 5 12345678", b, d); end
    model_access(32'h80000094, 0, eb, ed);
    do_access(32'h80000094, 1, 0, b, d);
    checks++;
    if (b !== 5 || d !== 32'h80000094) begin errors++; $display("FAIL old_line_remiss got busy %0d data %h exp 5 80000094", b, d); end
  endtask

  task automatic test_random();
    int b, eb, m;
    logic [31:0] a, d, ed;
    for (int n = 0; n < 120; n++) begin
      a = {24'($urandom_range(0, 5)), 4'($urandom_range(8, 9)), 4'($urandom_range(0, 15))};
      m = $urandom_range(1, 3);
      model_access(a, m[1], eb, ed);
      do_access(a, m[0], m[1], b, d);
      checks++;
      if (b !== eb || d !== ed) begin errors++; $display("FAIL random %0d addr %h got busy %0d data %h exp %0d %h", n, a, b, d, eb, ed); end
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_set0();
    test_eviction();
    test_write();
    test_reset_mid_fill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
